// File: rtl/rv32_pkg.sv
// Shared RV32 types, LSU state/cause enums and funct3 width codes.
// Also holds the access legality helpers used at request accept.
package rv32_pkg;

  typedef logic [31:0] rv32_register_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } rv32_lsu_state_t;

  typedef enum logic [1:0] {
    EXC_MISALIGN = 2'd0,
    EXC_ILLEGAL  = 2'd1,
    EXC_TIMEOUT  = 2'd2
  } rv32_lsu_exc_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  function automatic logic lsu_illegal(
    input logic       ld,
    input logic       st,
    input logic [2:0] f3
  );
    logic r;
    r = 1'b0;
    if (ld && st) r = 1'b1;
    else if (ld)
      r = !(f3 inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU});
    else
      r = !(f3 inside {LSU_B, LSU_H, LSU_W});
    return r;
  endfunction

  function automatic logic lsu_misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    return ((f3[1:0] == 2'b01) && a[0]) ||
           ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Store lane replication / byte enables and load extract / extend.
// Purely combinational.
module rv32_lsu_align
  import rv32_pkg::*;
(
  input  logic           i_is_load,
  input  logic [2:0]     i_funct3,
  input  logic [1:0]     i_addr_lo,
  input  rv32_register_t i_st_data,
  input  rv32_register_t i_ld_raw,
  output logic [3:0]     o_be,
  output rv32_register_t o_st_lanes,
  output rv32_register_t o_ld_data
);

  rv32_register_t w_lane;

  always_comb begin
    o_be       = 4'b1111;
    o_st_lanes = i_st_data;
    if (!i_is_load) begin
      unique case (i_funct3[1:0])
        2'b00: begin
          o_be       = 4'b0001 << i_addr_lo;
          o_st_lanes = {4{i_st_data[7:0]}};
        end
        2'b01: begin
          o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_st_lanes = {2{i_st_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign w_lane = i_ld_raw >> {i_addr_lo, 3'b000};

  always_comb begin
    o_ld_data = w_lane;
    unique case (i_funct3)
      LSU_B:  o_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
      LSU_H:  o_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
      LSU_BU: o_ld_data = {24'd0, w_lane[7:0]};
      LSU_HU: o_ld_data = {16'd0, w_lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// RV32 load/store unit: one req/gnt/rvalid transaction in flight,
// aligned writeback, misaligned/illegal/timeout exceptions.
module rv32_lsu
  import rv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           is_load,
  input  logic           is_store,
  input  logic [2:0]     funct3,
  input  rv32_register_t addr,
  input  rv32_register_t wdata,
  input  logic [4:0]     rd_idx,
  output logic           mem_req,
  output logic           mem_we,
  output rv32_register_t mem_addr,
  output logic [3:0]     mem_be,
  output rv32_register_t mem_wdata,
  input  logic           mem_gnt,
  input  logic           mem_rvalid,
  input  rv32_register_t mem_rdata,
  output logic           wb_valid,
  output logic [4:0]     wb_rd,
  output rv32_register_t wb_data,
  output logic           st_done,
  output logic           exc_valid,
  output logic [1:0]     exc_cause,
  output rv32_register_t exc_addr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  rv32_lsu_state_t r_state, w_next;
  logic [CW-1:0]   r_cnt;
  rv32_register_t  r_addr, r_wdata;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic            r_load;

  logic            r_wb_valid, r_st_done, r_exc_valid;
  logic [4:0]      r_wb_rd;
  rv32_register_t  r_wb_data, r_exc_addr;
  rv32_lsu_exc_t   r_exc_cause;

  logic            w_accept, w_illegal, w_misal, w_go;
  logic            w_limit, w_timeout, w_in_req, w_in_wait;
  logic [3:0]      w_be;
  rv32_register_t  w_st_lanes, w_ld_data;

  assign req_ready = (r_state == LSU_IDLE);
  assign w_in_req  = (r_state == LSU_REQ);
  assign w_in_wait = (r_state == LSU_WAIT);
  assign w_accept  = req_valid & req_ready & (is_load | is_store);
  assign w_illegal = lsu_illegal(is_load, is_store, funct3);
  assign w_misal   = lsu_misaligned(funct3, addr[1:0]);
  assign w_go      = w_accept & ~w_illegal & ~w_misal;
  assign w_limit   = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  // A response arriving on the limit cycle beats the timeout.
  assign w_timeout = w_limit &
                     ((w_in_req & ~mem_gnt) | (w_in_wait & ~mem_rvalid));

  rv32_lsu_align u_align (
    .i_is_load  (r_load),
    .i_funct3   (r_funct3),
    .i_addr_lo  (r_addr[1:0]),
    .i_st_data  (r_wdata),
    .i_ld_raw   (mem_rdata),
    .o_be       (w_be),
    .o_st_lanes (w_st_lanes),
    .o_ld_data  (w_ld_data)
  );

  assign mem_req   = w_in_req;
  assign mem_we    = w_in_req & ~r_load;
  assign mem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : '0;
  assign mem_be    = w_in_req ? w_be : 4'b0000;
  assign mem_wdata = w_in_req ? w_st_lanes : '0;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LSU_IDLE: if (w_go) w_next = LSU_REQ;
      LSU_REQ: begin
        if (mem_gnt)      w_next = r_load ? LSU_WAIT : LSU_IDLE;
        else if (w_limit) w_next = LSU_IDLE;
      end
      LSU_WAIT: begin
        if (mem_rvalid || w_limit) w_next = LSU_IDLE;
      end
      default: w_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LSU_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state || r_state == LSU_IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_load   <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= addr;
      r_wdata  <= wdata;
      r_funct3 <= funct3;
      r_rd     <= rd_idx;
      r_load   <= is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_st_done   <= 1'b0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= EXC_MISALIGN;
      r_exc_addr  <= '0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_st_done   <= 1'b0;
      r_exc_valid <= 1'b0;
      unique case (1'b1)
        w_accept & (w_illegal | w_misal): begin
          r_exc_valid <= 1'b1;
          r_exc_cause <= w_illegal ? EXC_ILLEGAL : EXC_MISALIGN;
          r_exc_addr  <= addr;
        end
        w_timeout: begin
          r_exc_valid <= 1'b1;
          r_exc_cause <= EXC_TIMEOUT;
          r_exc_addr  <= r_addr;
        end
        w_in_req & mem_gnt & ~r_load: r_st_done <= 1'b1;
        w_in_wait & mem_rvalid: begin
          r_wb_valid <= 1'b1;
          r_wb_rd    <= r_rd;
          r_wb_data  <= w_ld_data;
        end
        default: ;
      endcase
    end
  end

  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign st_done   = r_st_done;
  assign exc_valid = r_exc_valid;
  assign exc_cause = r_exc_cause;
  assign exc_addr  = r_exc_addr;

endmodule

// File: tb/tb_rv32_lsu.sv
// Directed bench for rv32_lsu: vector table plus
// timeout, back-to-back and async-reset sequences.
module tb_rv32_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic        is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd_idx;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        st_done, exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .rd_idx(rd_idx),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_done(st_done), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          kind;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] res;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs[14];
  vec_t v;

  function automatic vec_t mk(
    input logic ld, input logic st, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [4:0] rd, input logic [31:0] rdata,
    input int kind, input logic [3:0] be,
    input logic [31:0] mwd, input logic [31:0] res,
    input logic [1:0] cause
  );
    vec_t r;
    r.ld = ld; r.st = st; r.f3 = f3; r.a = a; r.wd = wd;
    r.rd = rd; r.rdata = rdata; r.kind = kind; r.be = be;
    r.mwd = mwd; r.res = res; r.cause = cause;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic ld, input logic st,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [4:0] rd);
    req_valid = 1'b1;
    is_load = ld; is_store = st; funct3 = f3;
    addr = a; wdata = wd; rd_idx = rd;
    step();
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1,0,3'b010,32'h100,0,5'd5,32'hDEADBEEF,
                  0,4'hF,0,32'hDEADBEEF,0);
    vecs[1]  = mk(1,0,3'b000,32'h103,0,5'd6,32'h80AABBCC,
                  0,4'hF,0,32'hFFFFFF80,0);
    vecs[2]  = mk(1,0,3'b100,32'h103,0,5'd7,32'h80AABBCC,
                  0,4'hF,0,32'h00000080,0);
    vecs[3]  = mk(1,0,3'b101,32'h102,0,5'd8,32'h80AABBCC,
                  0,4'hF,0,32'h000080AA,0);
    vecs[4]  = mk(1,0,3'b001,32'h102,0,5'd9,32'h80AABBCC,
                  0,4'hF,0,32'hFFFF80AA,0);
    vecs[5]  = mk(1,0,3'b000,32'h100,0,5'd31,32'h80AABBCC,
                  0,4'hF,0,32'hFFFFFFCC,0);
    vecs[6]  = mk(0,1,3'b000,32'h201,32'h12345678,0,0,
                  1,4'b0010,32'h78787878,0,0);
    vecs[7]  = mk(0,1,3'b001,32'h202,32'h12345678,0,0,
                  1,4'b1100,32'h56785678,0,0);
    vecs[8]  = mk(0,1,3'b010,32'h204,32'h12345678,0,0,
                  1,4'b1111,32'h12345678,0,0);
    vecs[9]  = mk(1,0,3'b001,32'h101,0,5'd1,0,2,0,0,0,2'd0);
    vecs[10] = mk(0,1,3'b010,32'h102,32'h1,0,0,2,0,0,0,2'd0);
    vecs[11] = mk(1,0,3'b011,32'h100,0,5'd1,0,2,0,0,0,2'd1);
    vecs[12] = mk(1,1,3'b010,32'h300,0,5'd1,0,2,0,0,0,2'd1);
    vecs[13] = mk(0,1,3'b100,32'h304,0,0,0,2,0,0,0,2'd1);

    rst_n = 1'b0;
    req_valid = 0; is_load = 0; is_store = 0; funct3 = 0;
    addr = 0; wdata = 0; rd_idx = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_pulses", {wb_valid, st_done, exc_valid}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_exc_addr", exc_addr, 0);
    step();
    rst_n = 1'b1;
    step();

    accept(0, 0, 3'b010, 32'h100, 0, 0);
    chk("neither_mem_req", mem_req, 0);
    chk("neither_exc", exc_valid, 0);
    chk("neither_ready", req_ready, 1);

    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      accept(v.ld, v.st, v.f3, v.a, v.wd, v.rd);
      if (v.kind == 2) begin
        chk($sformatf("v%0d_exc_valid", i), exc_valid, 1);
        chk($sformatf("v%0d_exc_cause", i), exc_cause, v.cause);
        chk($sformatf("v%0d_exc_addr", i), exc_addr, v.a);
        chk($sformatf("v%0d_no_req", i), mem_req, 0);
        step();
        chk($sformatf("v%0d_exc_pulse", i), exc_valid, 0);
        chk($sformatf("v%0d_no_req2", i), mem_req, 0);
        chk($sformatf("v%0d_ready", i), req_ready, 1);
      end else begin
        chk($sformatf("v%0d_mem_req", i), mem_req, 1);
        chk($sformatf("v%0d_mem_addr", i), mem_addr,
            {v.a[31:2], 2'b00});
        chk($sformatf("v%0d_mem_be", i), mem_be, v.be);
        chk($sformatf("v%0d_mem_we", i), mem_we, v.kind == 1);
        if (v.kind == 1)
          chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v.mwd);
        step();
        step();
        chk($sformatf("v%0d_req_hold", i), mem_req, 1);
        chk($sformatf("v%0d_be_hold", i), mem_be, v.be);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk($sformatf("v%0d_req_drop", i), mem_req, 0);
        if (v.kind == 1) begin
          chk($sformatf("v%0d_st_done", i), st_done, 1);
          chk($sformatf("v%0d_no_wb", i), wb_valid, 0);
          chk($sformatf("v%0d_ready", i), req_ready, 1);
          step();
          chk($sformatf("v%0d_st_pulse", i), st_done, 0);
        end else begin
          chk($sformatf("v%0d_wait_ready", i), req_ready, 0);
          mem_rvalid = 1'b1;
          mem_rdata = v.rdata;
          step();
          mem_rvalid = 1'b0;
          chk($sformatf("v%0d_wb_valid", i), wb_valid, 1);
          chk($sformatf("v%0d_wb_data", i), wb_data, v.res);
          chk($sformatf("v%0d_wb_rd", i), wb_rd, v.rd);
          chk($sformatf("v%0d_exc", i), exc_valid, 0);
          chk($sformatf("v%0d_ready", i), req_ready, 1);
          step();
          chk($sformatf("v%0d_wb_pulse", i), wb_valid, 0);
        end
      end
    end

    // back-to-back: accept a load in the st_done cycle
    accept(0, 1, 3'b010, 32'h700, 32'hA5A5A5A5, 0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("b2b_st_done", st_done, 1);
    chk("b2b_ready", req_ready, 1);
    accept(1, 0, 3'b010, 32'h704, 0, 5'd3);
    chk("b2b_mem_req", mem_req, 1);
    chk("b2b_mem_addr", mem_addr, 32'h704);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0BADF00D;
    step();
    mem_rvalid = 1'b0;
    chk("b2b_wb_data", wb_data, 32'h0BADF00D);

    // REQ timeout
    accept(0, 1, 3'b010, 32'h400, 32'h1, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_req_high%0d", k), mem_req, 1);
      step();
    end
    chk("to_req_low", mem_req, 0);
    chk("to_exc_valid", exc_valid, 1);
    chk("to_exc_cause", exc_cause, 2);
    chk("to_exc_addr", exc_addr, 32'h400);
    chk("to_ready", req_ready, 1);
    step();

    // gnt on the limit cycle wins
    accept(0, 1, 3'b010, 32'h404, 32'h2, 0);
    step(); step(); step();
    chk("lim_req_high", mem_req, 1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("lim_st_done", st_done, 1);
    chk("lim_no_exc", exc_valid, 0);
    step();

    // rvalid in REQ ignored, then WAIT timeout
    accept(1, 0, 3'b010, 32'h500, 0, 5'd4);
    mem_gnt = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h11111111;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    chk("wto_in_wait", req_ready, 0);
    step(); step(); step();
    chk("wto_before", exc_valid, 0);
    step();
    chk("wto_exc_valid", exc_valid, 1);
    chk("wto_exc_cause", exc_cause, 2);
    chk("wto_no_wb", wb_valid, 0);
    chk("wto_ready", req_ready, 1);
    step();

    // async reset in REQ
    accept(1, 0, 3'b010, 32'h600, 0, 5'd2);
    chk("ar_req_before", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req_drop", mem_req, 0);
    chk("ar_ready", req_ready, 1);
    step();
    rst_n = 1'b1;
    step();

    // async reset in WAIT, late rvalid ignored
    accept(1, 0, 3'b010, 32'h604, 0, 5'd2);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("arw_in_wait", req_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arw_ready", req_ready, 1);
    chk("arw_wb", wb_valid, 0);
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h22222222;
    step();
    mem_rvalid = 1'b0;
    chk("arw_late_rvalid", wb_valid, 0);
    chk("arw_mem_req", mem_req, 0);
    step();
    chk("arw_late_rvalid2", wb_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
